core_writeback: RTL and testbench
=================================

# core_writeback

Writeback stage of the RV32I core, directly upstream of the register file. It merges single-cycle ALU results with variable-latency data-memory load responses and formats load data by size, sign and byte offset. It drives the register-file write port (`we`, `r_num_write`, `data_in`) from registers and exports a pending-load mask so decode can stall on load-use hazards.

## Interface
Parameters:
- `DATA_WIDTH`, 32, datapath width.
- `REG_ADDR_WIDTH`, 5, register index width.
- `REG_DEPTH`, 32, number of architectural registers; sets the width of `pending_mask`.
- `LSU_DEPTH`, 2, maximum outstanding loads; this is the depth of the metadata FIFO.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: an ALU result is offered this cycle.
- `alu_rd` in REG_ADDR_WIDTH: destination register of the ALU result.
- `alu_result` in DATA_WIDTH: ALU result value.
- `alu_ready` out 1: the stage accepts the ALU result this cycle.
- `ld_issue` in 1: a load was granted by memory this cycle; push its metadata.
- `ld_rd` in REG_ADDR_WIDTH: destination register of the load.
- `ld_funct3` in 3: load type field.
- `ld_addr_lo` in 2: byte offset, address[1:0].
- `ld_issue_ready` out 1: the metadata FIFO is not full.
- `data_rvalid` in 1: a load response is present this cycle.
- `data_rdata` in DATA_WIDTH: raw 32-bit word read from memory.
- `we` out 1: register-file write enable.
- `r_num_write` out REG_ADDR_WIDTH: register-file write index.
- `data_in` out DATA_WIDTH: register-file write data.
- `pending_mask` out REG_DEPTH: bit i is set while a load targeting register i is outstanding.
- `err` out 1: sticky protocol or decode error flag.

## Operation
- **Metadata FIFO.** Circular buffer of `LSU_DEPTH` entries, each holding {rd, funct3, addr_lo}.
  - Push when `ld_issue & ld_issue_ready`.
  - Pop when `data_rvalid` and the FIFO is not empty.
  - `ld_issue_ready = !full`. There is no full-bypass: a push while full is dropped.
  - Push and pop in the same cycle (not full): occupancy is unchanged and the pointers wrap modulo `LSU_DEPTH`.
  - `data_rvalid` while empty: no write, no pop, `err` is set. A push in the same cycle never services that response.
- **Load formatting.** Uses the head entry.
  - 000 LB: byte `addr_lo`, sign-extended.
  - 001 LH: halfword `addr_lo[1]`, sign-extended; `addr_lo[0]` is ignored.
  - 010 LW: full word.
  - 100 LBU: byte `addr_lo`, zero-extended.
  - 101 LHU: halfword `addr_lo[1]`, zero-extended.
  - Any other funct3: write 0 and set `err`.
- **Arbitration.** A load response always wins the write port.
  - `alu_ready = !skid_full`.
  - An ALU result accepted in a cycle with a load response is captured in a one-entry skid register.
  - A full skid is written in the first cycle without `data_rvalid`.
  - An accepted ALU result with no load response and an empty skid is written directly.
- **x0.** Any write whose rd is 0 is suppressed (`we` stays 0), but the FIFO still pops and the skid still drains.
- **pending_mask.** Combinational OR of onehot(rd) over the valid FIFO entries; bit 0 is forced to 0. Duplicate rd values across entries are allowed.
- **Reset.** Drives `we`=0, `r_num_write`=0, `data_in`=0, FIFO empty, skid empty, `err`=0. After reset, `alu_ready`=1, `ld_issue_ready`=1, `pending_mask`=0. All inputs are ignored while `rst` is high.
- **Reset mid-operation.** Outstanding entries and the skid contents are discarded. Responses arriving after reset are treated as empty-FIFO errors.

## Timing
- ALU result accepted in cycle N (no collision): `we`/`r_num_write`/`data_in` are valid in cycle N+1 for exactly one cycle. The register file captures at the end of N+1, so the value is readable in N+2.
- Load response in cycle N: write is presented in N+1. The `pending_mask` bit clears in N+1.
- Collision in cycle N: the load is written in N+1. The skidded ALU result is written in the first subsequent cycle with no `data_rvalid`, earliest N+2. `alu_ready` is 0 from N+1 until the cycle the skid drains is registered.
- A `pending_mask` bit is set the cycle after the push.
- Minimum issue-to-response latency is 1 cycle.
- `we` never asserts for two sources in the same cycle.

## Test plan
- **Reset values.** Hold `rst` 2 cycles with `alu_valid`=1, `data_rvalid`=1 -> `we`=0, `pending_mask`=0, `err`=0, `alu_ready`=1 throughout.
- **ALU path.** ALU rd=5, result 0xDEADBEEF in cycle 3 -> `we`=1, `r_num_write`=5, `data_in`=0xDEADBEEF in cycle 4 only. ALU rd=0 -> `we` stays 0.
- **Load formats.** Issue loads with `data_rdata`=0x80F17F82:
  - LB off 0 -> 0xFFFFFF82
  - LBU off 3 -> 0x00000080
  - LH off 2 -> 0xFFFF80F1
  - LHU off 0 -> 0x00007F82
  - LW -> 0x80F17F82
  - funct3=011 -> 0 with `err`=1
- **Collision.** `alu_valid` (rd=7, 0x11) and `data_rvalid` (load rd=9, LW 0x22) in cycle N:
  - N+1: write x9=0x22, `alu_ready`=0.
  - N+2: write x7=0x11.
  - A second collision in N+2 delays x7 to N+3.
- **FIFO full and wrap.**
  - Two issues (rd=3, rd=4) -> `ld_issue_ready`=0 and `pending_mask`=0x18.
  - A third issue is dropped.
  - A response pops rd=3 (mask becomes 0x10) while a simultaneous new issue is refused.
  - Six alternating issue/response pairs return in order.
- **Spurious response.** `data_rvalid` with the FIFO empty -> no write, `err` stays 1 until `rst`. `rst` asserted with 2 loads outstanding -> mask=0, and later responses set `err`.

Source files
------------

// File: rtl/core_writeback.sv
// rtl/core_writeback.sv - RV32I writeback stage: merges ALU results and formatted load responses
// onto the register-file write port; tracks outstanding loads for hazard detection.
module core_writeback #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_DEPTH      = 32,
    parameter int LSU_DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    output logic                      alu_ready,
    input  logic                      ld_issue,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [2:0]                ld_funct3,
    input  logic [1:0]                ld_addr_lo,
    output logic                      ld_issue_ready,
    input  logic                      data_rvalid,
    input  logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      we,
    output logic [REG_ADDR_WIDTH-1:0] r_num_write,
    output logic [DATA_WIDTH-1:0]     data_in,
    output logic [REG_DEPTH-1:0]      pending_mask,
    output logic                      err
);
    localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;

    logic [REG_ADDR_WIDTH-1:0] ent_rd_q  [LSU_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] ent_rd_d  [LSU_DEPTH];
    logic [2:0]                ent_f3_q  [LSU_DEPTH];
    logic [2:0]                ent_f3_d  [LSU_DEPTH];
    logic [1:0]                ent_lo_q  [LSU_DEPTH];
    logic [1:0]                ent_lo_d  [LSU_DEPTH];
    logic [LSU_DEPTH-1:0]      ent_vld_q, ent_vld_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;

    logic                      skid_vld_q, skid_vld_d;
    logic [REG_ADDR_WIDTH-1:0] skid_rd_q, skid_rd_d;
    logic [DATA_WIDTH-1:0]     skid_data_q, skid_data_d;

    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      err_q, err_d;

    logic                      full, empty, push, pop, alu_acc;
    logic [2:0]                head_f3;
    logic [1:0]                head_lo;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      ld_bad;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LSU_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A slot is free exactly when its valid bit is clear, so occupancy needs no separate counter.
    assign full    = ent_vld_q[wr_ptr_q];
    assign empty   = !ent_vld_q[rd_ptr_q];
    assign push    = ld_issue && !full;
    assign pop     = data_rvalid && !empty;
    assign alu_acc = alu_valid && !skid_vld_q;

    assign head_f3  = ent_f3_q[rd_ptr_q];
    assign head_lo  = ent_lo_q[rd_ptr_q];
    assign byte_sel = data_rdata[{head_lo, 3'b000} +: 8];
    assign half_sel = data_rdata[{head_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = '0;
        ld_bad  = 1'b0;
        case (head_f3)
            3'b000:  ld_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  ld_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b010:  ld_data = data_rdata;
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: ld_bad  = 1'b1;
        endcase
    end

    always_comb begin
        ent_rd_d    = ent_rd_q;
        ent_f3_d    = ent_f3_q;
        ent_lo_d    = ent_lo_q;
        ent_vld_d   = ent_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        skid_vld_d  = skid_vld_q;
        skid_rd_d   = skid_rd_q;
        skid_data_d = skid_data_q;
        we_d        = 1'b0;
        wr_rd_d     = wr_rd_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;

        if (push) begin
            ent_rd_d[wr_ptr_q]  = ld_rd;
            ent_f3_d[wr_ptr_q]  = ld_funct3;
            ent_lo_d[wr_ptr_q]  = ld_addr_lo;
            ent_vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
        end

        // Any response cycle blocks the ALU/skid from the port; ALU results taken then wait in the skid.
        if (data_rvalid) begin
            if (pop) begin
                ent_vld_d[rd_ptr_q] = 1'b0;
                rd_ptr_d            = ptr_inc(rd_ptr_q);
                we_d                = (ent_rd_q[rd_ptr_q] != '0);
                wr_rd_d             = ent_rd_q[rd_ptr_q];
                wr_data_d           = ld_data;
                if (ld_bad) err_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (alu_acc) begin
                skid_vld_d  = 1'b1;
                skid_rd_d   = alu_rd;
                skid_data_d = alu_result;
            end
        end else if (skid_vld_q) begin
            skid_vld_d = 1'b0;
            we_d       = (skid_rd_q != '0);
            wr_rd_d    = skid_rd_q;
            wr_data_d  = skid_data_q;
        end else if (alu_acc) begin
            we_d      = (alu_rd != '0);
            wr_rd_d   = alu_rd;
            wr_data_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LSU_DEPTH; i++) begin
                ent_rd_q[i] <= '0;
                ent_f3_q[i] <= '0;
                ent_lo_q[i] <= '0;
            end
            ent_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            skid_vld_q  <= 1'b0;
            skid_rd_q   <= '0;
            skid_data_q <= '0;
            we_q        <= 1'b0;
            wr_rd_q     <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            ent_rd_q    <= ent_rd_d;
            ent_f3_q    <= ent_f3_d;
            ent_lo_q    <= ent_lo_d;
            ent_vld_q   <= ent_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            skid_vld_q  <= skid_vld_d;
            skid_rd_q   <= skid_rd_d;
            skid_data_q <= skid_data_d;
            we_q        <= we_d;
            wr_rd_q     <= wr_rd_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            for (int j = 0; j < REG_DEPTH; j++) begin
                if (ent_vld_q[i] && (ent_rd_q[i] == REG_ADDR_WIDTH'(j))) pending_mask[j] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign alu_ready      = !skid_vld_q;
    assign ld_issue_ready = !full;
    assign we             = we_q;
    assign r_num_write    = wr_rd_q;
    assign data_in        = wr_data_q;
    assign err            = err_q;
endmodule

// File: tb/tb_core_writeback.sv
// tb/tb_core_writeback.sv - directed self-checking bench for core_writeback.
module tb_core_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        ld_issue_ready;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        we;
    logic [4:0]  r_num_write;
    logic [31:0] data_in;
    logic [31:0] pending_mask;
    logic        err;

    int checks = 0;
    int errors = 0;

    core_writeback #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .REG_DEPTH(32), .LSU_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
        .ld_issue_ready(ld_issue_ready),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .we(we), .r_num_write(r_num_write), .data_in(data_in),
        .pending_mask(pending_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_result  = '0;
        ld_issue    = 1'b0;
        ld_rd       = '0;
        ld_funct3   = '0;
        ld_addr_lo  = '0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
        ld_issue   = 1'b1;
        ld_rd      = rd;
        ld_funct3  = f3;
        ld_addr_lo = lo;
    endtask

    task automatic test_reset();
        idle();
        rst         = 1'b1;
        alu_valid   = 1'b1;
        alu_rd      = 5'd5;
        alu_result  = 32'h1234;
        data_rvalid = 1'b1;
        issue(5'd6, 3'b010, 2'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (we !== 1'b0 || pending_mask !== 32'h0 || err !== 1'b0 || alu_ready !== 1'b1 ||
                ld_issue_ready !== 1'b1 || r_num_write !== 5'd0 || data_in !== 32'h0) begin
                errors++;
                $display("FAIL reset cyc%0d: we=%b mask=%h err=%b alu_ready=%b ld_rdy=%b rnw=%0d din=%h, want 0,0,0,1,1,0,0",
                         c, we, pending_mask, err, alu_ready, ld_issue_ready, r_num_write, data_in);
            end
        end
        rst = 1'b0;
        idle();
        tick();
        checks++;
        if (we !== 1'b0 || pending_mask !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: we=%b mask=%h err=%b, want 0,0,0", we, pending_mask, err);
        end
    endtask

    task automatic test_alu();
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'hDEADBEEF;
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd5 || data_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_write: we=%b rd=%0d data=%h, want 1,5,deadbeef", we, r_num_write, data_in);
        end
        idle();
        tick();
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: we=%b, want 0", we);
        end
        alu_valid  = 1'b1;
        alu_rd     = 5'd0;
        alu_result = 32'h55;
        tick();
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL alu_x0: we=%b, want 0", we);
        end
        idle();
    endtask

    task automatic test_collision();
        issue(5'd9, 3'b010, 2'd0);
        tick();
        idle();
        alu_valid   = 1'b1;
        alu_rd      = 5'd7;
        alu_result  = 32'h11;
        data_rvalid = 1'b1;
        data_rdata  = 32'h22;
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd9 || data_in !== 32'h22 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_load: we=%b rd=%0d data=%h alu_ready=%b, want 1,9,22,0", we, r_num_write, data_in, alu_ready);
        end
        idle();
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd7 || data_in !== 32'h11 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_skid: we=%b rd=%0d data=%h alu_ready=%b, want 1,7,11,1", we, r_num_write, data_in, alu_ready);
        end
        // second response right after the collision holds the skid one more cycle
        issue(5'd9, 3'b010, 2'd0);
        tick();
        issue(5'd10, 3'b010, 2'd0);
        tick();
        idle();
        alu_valid   = 1'b1;
        alu_rd      = 5'd7;
        alu_result  = 32'h11;
        data_rvalid = 1'b1;
        data_rdata  = 32'h22;
        tick();
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 32'h33;
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd10 || data_in !== 32'h33 || alu_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll2_load: we=%b rd=%0d data=%h alu_ready=%b, want 1,10,33,0", we, r_num_write, data_in, alu_ready);
        end
        idle();
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd7 || data_in !== 32'h11 || alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll2_skid: we=%b rd=%0d data=%h alu_ready=%b, want 1,7,11,1", we, r_num_write, data_in, alu_ready);
        end
        tick();
        checks++;
        if (we !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL coll_quiet: we=%b err=%b, want 0,0", we, err);
        end
    endtask

    task automatic test_fifo_full_wrap();
        logic [4:0] prev;
        issue(5'd3, 3'b010, 2'd0);
        tick();
        issue(5'd4, 3'b010, 2'd0);
        tick();
        checks++;
        if (ld_issue_ready !== 1'b0 || pending_mask !== 32'h18) begin
            errors++;
            $display("FAIL fifo_full: ld_rdy=%b mask=%h, want 0,00000018", ld_issue_ready, pending_mask);
        end
        issue(5'd5, 3'b010, 2'd0);
        tick();
        checks++;
        if (pending_mask !== 32'h18) begin
            errors++;
            $display("FAIL fifo_drop: mask=%h, want 00000018", pending_mask);
        end
        issue(5'd6, 3'b010, 2'd0);
        data_rvalid = 1'b1;
        data_rdata  = 32'hA3;
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd3 || data_in !== 32'hA3 || pending_mask !== 32'h10 || ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_pop_refuse: we=%b rd=%0d data=%h mask=%h ld_rdy=%b, want 1,3,a3,00000010,1",
                     we, r_num_write, data_in, pending_mask, ld_issue_ready);
        end
        idle();
        data_rvalid = 1'b1;
        data_rdata  = 32'hA4;
        tick();
        checks++;
        if (we !== 1'b1 || r_num_write !== 5'd4 || data_in !== 32'hA4 || pending_mask !== 32'h0) begin
            errors++;
            $display("FAIL fifo_pop2: we=%b rd=%0d data=%h mask=%h, want 1,4,a4,0", we, r_num_write, data_in, pending_mask);
        end
        // issue/response pairs overlapped so pointers wrap several times
        idle();
        issue(5'd11, 3'b010, 2'd0);
        tick();
        prev = 5'd11;
        for (int k = 12; k <= 17; k++) begin
            idle();
            if (k <= 16) issue(5'(k), 3'b010, 2'd0);
            data_rvalid = 1'b1;
            data_rdata  = {24'h0, 3'b000, prev};
            tick();
            checks++;
            if (we !== 1'b1 || r_num_write !== prev || data_in !== {24'h0, 3'b000, prev} ||
                pending_mask !== ((k <= 16) ? (32'h1 << k) : 32'h0)) begin
                errors++;
                $display("FAIL wrap_%0d: we=%b rd=%0d data=%h mask=%h, want rd=%0d", k, we, r_num_write, data_in, pending_mask, prev);
            end
            prev = 5'(k);
        end
        idle();
        tick();
        checks++;
        if (err !== 1'b0 || ld_issue_ready !== 1'b1 || we !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: err=%b ld_rdy=%b we=%b, want 0,1,0", err, ld_issue_ready, we);
        end
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3_tab  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [1:0]  lo_tab  [6] = '{2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 2'd0};
        logic [31:0] exp_tab [6] = '{32'hFFFFFF82, 32'h00000080, 32'hFFFF80F1, 32'h00007F82, 32'h80F17F82, 32'h0};
        for (int i = 0; i < 6; i++) begin
            idle();
            issue(5'(20 + i), f3_tab[i], lo_tab[i]);
            tick();
            checks++;
            if (pending_mask !== (32'h1 << (20 + i))) begin
                errors++;
                $display("FAIL fmt_mask_%0d: mask=%h, want %h", i, pending_mask, 32'h1 << (20 + i));
            end
            idle();
            data_rvalid = 1'b1;
            data_rdata  = 32'h80F17F82;
            tick();
            checks++;
            if (we !== 1'b1 || r_num_write !== 5'(20 + i) || data_in !== exp_tab[i] ||
                err !== (i == 5) || pending_mask !== 32'h0) begin
                errors++;
                $display("FAIL fmt_%0d: we=%b rd=%0d data=%h err=%b mask=%h, want data=%h err=%b",
                         i, we, r_num_write, data_in, err, pending_mask, exp_tab[i], i == 5);
            end
        end
        idle();
    endtask

    task automatic test_spurious();
        do_reset();
        data_rvalid = 1'b1;
        data_rdata  = 32'h77;
        tick();
        checks++;
        if (we !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL spur: we=%b err=%b, want 0,1", we, err);
        end
        idle();
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: err=%b, want 1", err);
        end
        issue(5'd2, 3'b010, 2'd0);
        tick();
        issue(5'd8, 3'b010, 2'd0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        checks++;
        if (pending_mask !== 32'h0 || err !== 1'b0 || ld_issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset: mask=%h err=%b ld_rdy=%b, want 0,0,1", pending_mask, err, ld_issue_ready);
        end
        rst         = 1'b0;
        data_rvalid = 1'b1;
        data_rdata  = 32'h99;
        tick();
        checks++;
        if (we !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_resp: we=%b err=%b, want 0,1", we, err);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_alu();
        test_collision();
        test_fifo_full_wrap();
        test_load_formats();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
